// File: rtl/writeback_unit.sv
// Writeback stage: registers ALU/PC+4 results or waits for and extends load data
// before driving the register-file write port.
module writeback_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_regwrite,
  input  logic [1:0]      in_wbsel,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            load_busy,
  output logic            load_error,
  output logic [31:0]     retired
);

  localparam int unsigned CntW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(LOAD_TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWaitLoad} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic              ld_we_q, ld_we_d;
  logic [2:0]        ld_funct3_q, ld_funct3_d;
  logic [1:0]        ld_addr_q, ld_addr_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_data_q, rf_data_d;
  logic              err_q, err_d;
  logic [31:0]       retired_q, retired_d;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_ext;

  // Byte/halfword selection uses the offset latched at acceptance.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    unique case (ld_addr_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = ld_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (ld_funct3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_rd_d     = ld_rd_q;
    ld_we_d     = ld_we_q;
    ld_funct3_d = ld_funct3_q;
    ld_addr_d   = ld_addr_q;
    rf_we_d     = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_data_d   = rf_data_q;
    err_d       = err_q;
    retired_d   = retired_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_wbsel == 2'b01) begin
            state_d     = StWaitLoad;
            cnt_d       = '0;
            ld_rd_d     = in_rd;
            ld_we_d     = in_regwrite && (in_rd != 5'd0);
            ld_funct3_d = in_funct3;
            ld_addr_d   = in_addr_lo;
          end else begin
            retired_d = retired_q + 32'd1;
            // Reserved wbsel and x0 targets retire without writing.
            if (in_regwrite && (in_rd != 5'd0) && (in_wbsel != 2'b11)) begin
              rf_we_d   = 1'b1;
              rf_rd_d   = in_rd;
              rf_data_d = in_wbsel[1] ? in_pc4 : in_alu;
            end
          end
        end
      end
      StWaitLoad: begin
        if (mem_rvalid) begin
          state_d   = StIdle;
          retired_d = retired_q + 32'd1;
          if (ld_we_q) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = ld_rd_q;
            rf_data_d = ld_ext;
          end
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ld_rd_q     <= '0;
      ld_we_q     <= 1'b0;
      ld_funct3_q <= '0;
      ld_addr_q   <= '0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_data_q   <= '0;
      err_q       <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_rd_q     <= ld_rd_d;
      ld_we_q     <= ld_we_d;
      ld_funct3_q <= ld_funct3_d;
      ld_addr_q   <= ld_addr_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_data_q   <= rf_data_d;
      err_q       <= err_d;
      retired_q   <= retired_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign load_busy  = (state_q == StWaitLoad);
  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_data    = rf_data_q;
  assign load_error = err_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random transactions checked
// against a transaction-level model of the writeback rules.
module tb_writeback_unit;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic [1:0]  in_wbsel;
  logic [31:0] in_alu;
  logic [31:0] in_pc4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        load_busy;
  logic        load_error;
  logic [31:0] retired;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state: what the write port and counters must show.
  logic [31:0] exp_retired = 0;
  logic [4:0]  last_rd = 0;
  logic [31:0] last_data = 0;
  logic        exp_err = 0;

  writeback_unit #(.XLEN(32), .LOAD_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_regwrite(in_regwrite),
    .in_wbsel   (in_wbsel),
    .in_alu     (in_alu),
    .in_pc4     (in_pc4),
    .in_funct3  (in_funct3),
    .in_addr_lo (in_addr_lo),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_data    (rf_data),
    .load_busy  (load_busy),
    .load_error (load_error),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load result from arithmetic on the fetched word.
  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] al,
                                             input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * al)) % 256;
    h = (w >> (16 * al[1])) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b - 32'd256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic check_outputs(input string tag, input logic we);
    chk({tag, "_we"}, 32'(rf_we), 32'(we));
    chk({tag, "_rd"}, 32'(rf_rd), 32'(last_rd));
    chk({tag, "_data"}, rf_data, last_data);
    chk({tag, "_retired"}, retired, exp_retired);
    chk({tag, "_err"}, 32'(load_error), 32'(exp_err));
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"}, 32'(load_busy), 32'd0);
  endtask

  // One instruction; dly = wait cycle (1-based) carrying mem_rvalid, > TMO means never.
  task automatic do_txn(input logic [4:0] rd, input logic rw, input logic [1:0] ws,
                        input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [2:0] f3, input logic [1:0] al,
                        input int unsigned dly, input logic [31:0] word);
    logic we;
    we = rw && (rd != 0) && (ws != 2'b11);
    @(negedge clk);
    check_outputs("pre", 1'b0);
    in_valid = 1'b1; in_rd = rd; in_regwrite = rw; in_wbsel = ws;
    in_alu = alu; in_pc4 = pc4; in_funct3 = f3; in_addr_lo = al;
    mem_rvalid = 1'($urandom_range(0, 1));  // must be ignored while idle
    mem_rdata = $urandom;
    @(negedge clk);
    in_valid = 1'b0; mem_rvalid = 1'b0;
    in_rd = 5'($urandom); in_funct3 = 3'($urandom); in_addr_lo = 2'($urandom);
    if (ws != 2'b01) begin
      exp_retired = exp_retired + 1;
      if (we) begin
        last_rd = rd;
        last_data = ws[1] ? pc4 : alu;
      end
      check_outputs("alu", we);
    end else begin
      for (int i = 1; i <= TMO && i <= dly; i++) begin
        chk("wait_busy", 32'(load_busy), 32'd1);
        chk("wait_ready", 32'(in_ready), 32'd0);
        chk("wait_we", 32'(rf_we), 32'd0);
        if (i == dly) begin
          mem_rvalid = 1'b1;
          mem_rdata = word;
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
      if (dly <= TMO) begin
        exp_retired = exp_retired + 1;
        if (we) begin
          last_rd = rd;
          last_data = load_value(f3, al, word);
        end
        check_outputs("load", we);
      end else begin
        exp_err = 1'b1;
        check_outputs("tmo", 1'b0);
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_regwrite = 1'b0; in_wbsel = '0;
    in_alu = '0; in_pc4 = '0; in_funct3 = '0; in_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    #23;
    check_outputs("reset", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Back-to-back ALU results.
    in_valid = 1'b1; in_rd = 5'd5; in_regwrite = 1'b1; in_wbsel = 2'b00;
    in_alu = 32'h12345678;
    @(negedge clk);
    chk("b2b_we0", 32'(rf_we), 32'd1);
    chk("b2b_rd0", 32'(rf_rd), 32'd5);
    chk("b2b_data0", rf_data, 32'h12345678);
    chk("b2b_ready", 32'(in_ready), 32'd1);
    in_rd = 5'd6; in_alu = 32'hA;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_we1", 32'(rf_we), 32'd1);
    chk("b2b_rd1", 32'(rf_rd), 32'd6);
    chk("b2b_data1", rf_data, 32'hA);
    chk("b2b_retired", retired, 32'd2);
    exp_retired = 2; last_rd = 5'd6; last_data = 32'hA;

    // Load extension corners.
    do_txn(5'd7, 1'b1, 2'b01, 0, 0, 3'b000, 2'd2, 1, 32'h00800000);
    chk("lb_lit", rf_data, 32'hFFFFFF80);
    do_txn(5'd7, 1'b1, 2'b01, 0, 0, 3'b100, 2'd2, 1, 32'h00800000);
    chk("lbu_lit", rf_data, 32'h00000080);
    do_txn(5'd8, 1'b1, 2'b01, 0, 0, 3'b101, 2'd2, 1, 32'h80010000);
    chk("lhu_lit", rf_data, 32'h00008001);

    // Three-cycle wait, then rd=0 PC+4.
    do_txn(5'd9, 1'b1, 2'b01, 0, 0, 3'b010, 2'd0, 3, 32'hCAFEF00D);
    do_txn(5'd0, 1'b1, 2'b10, 32'h1, 32'h1004, 3'b000, 2'd0, 0, 0);

    // Random transactions; load delays may reach the timeout boundary.
    for (int n = 0; n < 60; n++) begin
      do_txn(5'($urandom), 1'($urandom_range(0, 7) != 0), 2'($urandom), $urandom, $urandom,
             3'($urandom), 2'($urandom), $urandom_range(1, TMO), $urandom);
    end

    // Timeout with no response.
    do_txn(5'd3, 1'b1, 2'b01, 0, 0, 3'b010, 2'd0, TMO + 5, 0);
    chk("tmo_error_lit", 32'(load_error), 32'd1);

    // Reset during a wait, then a stray response.
    @(negedge clk);
    in_valid = 1'b1; in_rd = 5'd11; in_regwrite = 1'b1; in_wbsel = 2'b01; in_funct3 = 3'b010;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_mid_busy", 32'(load_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    exp_retired = 0; last_rd = 0; last_data = 0; exp_err = 0;
    check_outputs("rst_async", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check_outputs("rst_after", 1'b0);

    do_txn(5'd12, 1'b1, 2'b01, 0, 0, 3'b001, 2'd0, 2, 32'h00008000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and register-file write width.
REQ-002 SHALL have parameter LOAD_TIMEOUT, default 16: maximum WAIT_LOAD cycles before the load is abandoned.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: the MEM stage presents an instruction.
REQ-006 SHALL have port in_ready, output, 1: the unit accepts the instruction this cycle.
REQ-007 SHALL have ports in_rd (input, 5, destination register) and in_regwrite (input, 1, instruction writes rd).
REQ-008 SHALL have port in_wbsel, input, 2: 00 selects ALU result, 01 load data, 10 PC+4, 11 reserved.
REQ-009 SHALL have ports in_alu (input, XLEN, ALU result) and in_pc4 (input, XLEN, PC+4).
REQ-010 SHALL have ports in_funct3 (input, 3, load width code) and in_addr_lo (input, 2, load byte offset).
REQ-011 SHALL have ports mem_rvalid (input, 1, load data valid) and mem_rdata (input, XLEN, aligned memory word).
REQ-012 SHALL have ports rf_we (output, 1), rf_rd (output, 5) and rf_data (output, XLEN): the register-file write port.
REQ-013 SHALL have port load_busy, output, 1: high while in WAIT_LOAD.
REQ-014 SHALL have port load_error, output, 1: sticky flag, set on a load timeout.
REQ-015 SHALL have port retired, output, 32: count of completed instructions.

Function
REQ-016 SHALL implement the FSM states IDLE and WAIT_LOAD; in_ready = (state==IDLE).
REQ-017 SHALL accept an instruction on a rising edge where in_valid && in_ready; outputs are registered.
REQ-018 SHALL handle an accepted non-load (wbsel != 01) as follows:
- rf_we, rf_rd and rf_data are valid during the next cycle (1-cycle latency);
- the state stays IDLE, so back-to-back acceptance every cycle is possible.
REQ-019 SHALL handle an accepted load (wbsel == 01) as follows:
- the state goes to WAIT_LOAD and in_ready is low;
- rd, funct3 and addr_lo are latched.
REQ-020 SHALL, in WAIT_LOAD on the edge where mem_rvalid=1:
- register the extended data;
- go to IDLE;
- drive rf_we during the following cycle.
REQ-021 SHALL extend load data from mem_rdata as follows:
- funct3 000 (LB): byte at addr_lo, sign-extended; 100 (LBU): same byte, zero-extended;
- funct3 001 (LH): halfword at addr_lo[1], sign-extended; 101 (LHU): same halfword, zero-extended;
- funct3 010 and all other codes: full word.
REQ-022 SHALL force rf_we=0 when rd==0, when regwrite==0, or when wbsel==11; such an instruction still completes and counts as retired.
REQ-023 SHALL hold rf_we high for exactly one cycle per completed instruction; rf_rd and rf_data hold their last values while rf_we is low.
REQ-024 SHALL ignore mem_rvalid while in IDLE, including when it arrives in the same cycle as a load is accepted.
REQ-025 SHALL, on a load timeout:
- count WAIT_LOAD cycles, with the counter cleared on entry;
- after LOAD_TIMEOUT cycles without mem_rvalid, go to IDLE with no write, set load_error, and not increment retired.
REQ-026 SHALL increment retired (wrapping modulo 2^32) on the edge that registers a completion.

Reset
REQ-027 SHALL, while rst=0, immediately force: state IDLE, rf_we=0, rf_rd=0, rf_data=0, load_error=0, retired=0 and the timeout counter to 0.
REQ-028 SHALL abandon any in-flight load when reset is asserted mid-operation, with no write afterward.
REQ-029 SHALL assert in_ready in the first cycle after rst deasserts.

Verification
REQ-030 SHALL check ALU back-to-back: accept rd=5 alu=0x12345678 and then rd=6 alu=0xA on consecutive cycles -> rf_we high for two consecutive cycles with (5, 0x12345678) then (6, 0xA); retired=2.
REQ-031 SHALL check load sign-extension: LB addr_lo=2, rdata=0x00800000 -> rf_data=0xFFFFFF80; LBU -> 0x00000080; LHU addr_lo=2, rdata=0x80010000 -> 0x00008001.
REQ-032 SHALL check a load wait: mem_rvalid arrives 3 cycles after acceptance -> in_ready and load_busy reflect the wait for 3 cycles, one write follows, and in_ready returns high.
REQ-033 SHALL check a timeout: load accepted and mem_rvalid never asserted -> after 16 cycles load_error=1, no rf_we, retired unchanged, IDLE.
REQ-034 SHALL check the rd==0 case: PC+4 instruction with rd=0 -> rf_we stays 0 and retired increments by 1.
REQ-035 SHALL check reset mid-load: rst pulsed low during WAIT_LOAD, then mem_rvalid asserted -> no write occurs and all outputs read zero.
